// File: rtl/data_cache_pkg.sv
// Shared CPU package for the data cache: default geometry, load/store
// funct3 codes and the cache controller state encoding.
package data_cache_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_SETS           = 64;
  localparam int DEFAULT_WORDS_PER_LINE = 4;

  localparam logic [2:0] F3_BYTE  = 3'b000;
  localparam logic [2:0] F3_HALF  = 3'b001;
  localparam logic [2:0] F3_WORD  = 3'b010;
  localparam logic [2:0] F3_BYTEU = 3'b100;
  localparam logic [2:0] F3_HALFU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } cache_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data cache: load extraction/extension and
// store data replication plus byte strobes, selected by funct3 and addr[1:0].
module mem_lane_align
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [1:0]            offset_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] store_data_i,
  input  logic [DATA_WIDTH-1:0] load_word_i,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [3:0]            store_strb_o,
  output logic [DATA_WIDTH-1:0] load_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfwords ignore offset bit 0 so misaligned accesses align down.
  assign byte_sel = load_word_i[{offset_i, 3'b000} +: 8];
  assign half_sel = load_word_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    load_data_o  = load_word_i;
    store_data_o = store_data_i;
    store_strb_o = 4'b1111;
    case (funct3_i)
      F3_BYTE: begin
        load_data_o  = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
        store_data_o = {(DATA_WIDTH/8){store_data_i[7:0]}};
        store_strb_o = 4'b0001 << offset_i;
      end
      F3_HALF: begin
        load_data_o  = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        store_data_o = {(DATA_WIDTH/16){store_data_i[15:0]}};
        store_strb_o = offset_i[1] ? 4'b1100 : 4'b0011;
      end
      F3_BYTEU: load_data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      F3_HALFU: load_data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      F3_WORD:  load_data_o = load_word_i;
      default:  load_data_o = load_word_i;
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache sitting in the
// Memory stage; misses refill a whole line, stores always go to memory.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int SETS           = DEFAULT_SETS,
  parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int SB = $clog2(SETS);
  localparam int TW = DATA_WIDTH - 2 - WB - SB;
  localparam logic [WB-1:0] LAST_BEAT = WB'(WORDS_PER_LINE - 1);

  cache_state_e          state_q, state_d;
  logic [WB-1:0]         cnt_q, cnt_d;
  logic [SETS-1:0]       valid_q;
  logic [TW-1:0]         tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS*WORDS_PER_LINE];
  logic [DATA_WIDTH-1:0] addr_q, wdata_q;
  logic                  we_q;
  logic [2:0]            funct3_q;

  logic [DATA_WIDTH-1:0] cur_addr;
  logic [2:0]            cur_funct3;
  logic [SB-1:0]         cur_set;
  logic [WB-1:0]         cur_word;
  logic [TW-1:0]         cur_tag;
  logic                  hit;
  logic [DATA_WIDTH-1:0] line_word, load_data, store_data;
  logic [3:0]            store_strb;

  // Live request in IDLE, the captured copy while the operation is in flight.
  assign cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
  assign cur_set    = cur_addr[2+WB +: SB];
  assign cur_word   = cur_addr[2 +: WB];
  assign cur_tag    = cur_addr[DATA_WIDTH-1 -: TW];
  assign hit        = valid_q[cur_set] && (tag_q[cur_set] == cur_tag);
  assign line_word  = data_q[{cur_set, cur_word}];

  mem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .offset_i    (cur_addr[1:0]),
    .funct3_i    (cur_funct3),
    .store_data_i(wdata_q),
    .load_word_i (line_word),
    .store_data_o(store_data),
    .store_strb_o(store_strb),
    .load_data_o (load_data)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    rdata     = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = 4'b0000;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            stall   = 1'b1;
            state_d = WRITE;
          end else if (hit) begin
            rdata = load_data;
          end else begin
            stall   = 1'b1;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
        mem_addr  = {addr_q[DATA_WIDTH-1:2+WB], cnt_q, 2'b00};
        if (mem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        stall     = 1'b1;
        mem_valid = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
        mem_wdata = store_data;
        mem_wstrb = store_strb;
        if (mem_ready) state_d = DONE;
      end
      DONE: begin
        if (!we_q) rdata = load_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset quiets every output immediately, not just after the edge.
    if (!rst) begin
      state_d   = IDLE;
      cnt_d     = '0;
      stall     = 1'b0;
      rdata     = '0;
      mem_valid = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        we_q     <= req_we;
        funct3_q <= req_funct3;
        // Invalidate up front so an aborted refill never leaves a stale hit.
        if (!req_we && !hit) valid_q[cur_set] <= 1'b0;
      end
      if (state_q == REFILL && mem_ready && cnt_q == LAST_BEAT)
        valid_q[cur_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (state_q == REFILL && mem_ready) begin
        data_q[{cur_set, cnt_q}] <= mem_rdata;
        if (cnt_q == LAST_BEAT) tag_q[cur_set] <= cur_tag;
      end
      if (state_q == WRITE && mem_ready && hit) begin
        for (int b = 0; b < 4; b++) begin
          if (store_strb[b]) data_q[{cur_set, cur_word}][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule
